// File: rtl/mux2_bus_arbiter_pkg.sv
// mux2_bus_arbiter_pkg
// Shared definitions for the two-requester bus arbiter:
//   - arb_state_t : FSM encoding (ST_IDLE=0, ST_G0=1, ST_G1=2)
//   - DEF_MAX_HOLD: default burst limit before a forced hand-over
//   - DEF_CNT_W   : default hold-counter width
//   - STATS_W     : width of the optional grant-beat counters
// The next-owner picker reuses the state encoding so wider arbiters can
// share it.
package mux2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_CNT_W    = 3;
  localparam int STATS_W      = 16;

endpackage

// File: rtl/mux2_bus_arbiter_rr_pick.sv
// rr_pick
// Combinational next-owner logic for a round-robin two-way arbiter.
// Ports:
//   req0_i, req1_i   requests from side 0 / side 1
//   last_served_i    side that most recently gave up the bus
//   owner_i          current FSM state (arb_state_t encoding)
//   hold_expired_i   current owner is on the last beat of its burst
//   next_state_o     FSM state for the next cycle
module rr_pick
  import mux2_bus_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_served_i,
  input  logic [1:0] owner_i,
  input  logic       hold_expired_i,
  output logic [1:0] next_state_o
);

  arb_state_t nxt;

  always_comb begin
    nxt = ST_IDLE;
    case (arb_state_t'(owner_i))
      ST_IDLE: begin
        // On a tie the side that was not served last wins.
        if (req0_i && (!req1_i || last_served_i)) nxt = ST_G0;
        else if (req1_i)                          nxt = ST_G1;
        else                                      nxt = ST_IDLE;
      end
      ST_G0: begin
        if (!req0_i)                      nxt = req1_i ? ST_G1 : ST_IDLE;
        else if (hold_expired_i && req1_i) nxt = ST_G1;
        else                              nxt = ST_G0;
      end
      ST_G1: begin
        if (!req1_i)                      nxt = req0_i ? ST_G0 : ST_IDLE;
        else if (hold_expired_i && req0_i) nxt = ST_G0;
        else                              nxt = ST_G1;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign next_state_o = nxt;

endmodule

// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter
// Round-robin arbiter that owns the select of one WIDTH-bit 2:1 mux and
// registers the selected operand onto a shared bus with a valid strobe.
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   req0, I0          requester 0 request (held for the transfer) and data
//   req1, I1          requester 1 request and data
//   gnt0, gnt1        registered grants, never both high
//   sel               registered mux select (0=I0, 1=I1), holds when idle
//   o, o_valid        registered bus data and beat strobe
//   gcnt0, gcnt1      grant-beat counters; built only when ARB_STATS_EN is
//                     defined, otherwise tied to zero
// Handshake: a beat is produced on every rising edge where the FSM is in Gx
// and reqx is high; o/o_valid show it in the following cycle. Grant follows
// the request by one cycle, the first beat follows the grant by one cycle.
module mux2_bus_arbiter
  import mux2_bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [WIDTH-1:0]   I0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   I1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               sel,
  output logic [WIDTH-1:0]   o,
  output logic               o_valid,
  output logic [STATS_W-1:0] gcnt0,
  output logic [STATS_W-1:0] gcnt1
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [1:0]       next_w;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             sel_q;
  logic [WIDTH-1:0] o_q;
  logic             valid_q;

  logic             beat0, beat1, beat;
  logic             hold_expired;
  logic [WIDTH-1:0] mux_out;

  assign beat0 = (state_q == ST_G0) && req0;
  assign beat1 = (state_q == ST_G1) && req1;
  assign beat  = beat0 | beat1;

  // True on the beat that brings the burst length up to MAX_HOLD.
  assign hold_expired = (cnt_q == HOLD_LAST);

  // The one shared datapath mux; sel_q already points at the owner while
  // in a grant state.
  assign mux_out = sel_q ? I1 : I0;

  rr_pick u_pick (
    .req0_i         (req0),
    .req1_i         (req1),
    .last_served_i  (last_q),
    .owner_i        (state_q),
    .hold_expired_i (hold_expired),
    .next_state_o   (next_w)
  );

  assign state_d = arb_state_t'(next_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= beat;
      if (beat) o_q <= mux_out;

      // Counter clears on burst-limit wrap, on a drop and while idle.
      if (beat && !hold_expired) cnt_q <= cnt_q + 1'b1;
      else                       cnt_q <= '0;

      // last_served only moves when a side actually gives up the bus;
      // a wrap with nobody waiting keeps the owner and its history.
      if (state_q == ST_G0 && state_d != ST_G0) last_q <= 1'b0;
      if (state_q == ST_G1 && state_d != ST_G1) last_q <= 1'b1;

      if (state_d == ST_G0)      sel_q <= 1'b0;
      else if (state_d == ST_G1) sel_q <= 1'b1;
    end
  end

  assign gnt0    = (state_q == ST_G0);
  assign gnt1    = (state_q == ST_G1);
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = valid_q;

`ifdef ARB_STATS_EN
  logic [STATS_W-1:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (beat0) gcnt0_q <= gcnt0_q + 1'b1;
      if (beat1) gcnt1_q <= gcnt1_q + 1'b1;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`else
  assign gcnt0 = '0;
  assign gcnt1 = '0;
`endif

endmodule

// File: doc/mux2_bus_arbiter.md
Name: mux2_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit 2:1 datapath mux between two requesters.
- Owns the mux select, grants one requester at a time and registers the selected operand onto a shared output bus with a valid strobe.
- Sits in front of the ALU operand path; game-logic units (e.g. bomb timer, player update) request the bus through it.

Parameters:
- WIDTH, 8: data width of each requester input and of the output bus.
- MAX_HOLD, 4: max consecutive granted cycles before a forced switch when the other side is waiting; legal range 1..7.
- CNT_W, 3: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0  in  1  requester 0 wants the bus; held high for the whole transfer.
- I0  in  WIDTH  requester 0 data.
- req1  in  1  requester 1 wants the bus.
- I1  in  WIDTH  requester 1 data.
- gnt0  out  1  requester 0 owns the bus (registered).
- gnt1  out  1  requester 1 owns the bus (registered).
- sel  out  1  mux select, 0 = I0, 1 = I1 (registered; holds last value when idle).
- o  out  WIDTH  registered bus data.
- o_valid  out  1  o carries a valid beat this cycle.
- gcnt0  out  16  grant-beat counter, requester 0 (see Optional Feature).
- gcnt1  out  16  grant-beat counter, requester 1 (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - gnt0=gnt1=0, sel=0, o=0, o_valid=0.
  - State IDLE; hold counter 0; last_served=1, so requester 0 wins first.
  - Reset asserted mid-transfer clears everything immediately. No beat completes on that edge.
- States: IDLE, G0, G1. gnt0=(state==G0), gnt1=(state==G1), sel follows the granted side.
- IDLE:
  - Only req0 -> G0. Only req1 -> G1.
  - Both -> the side != last_served. Neither -> stay IDLE.
  - o_valid=0 in IDLE; o holds its last value.
- Gx, with y the other side:
  - Each edge with reqx=1: o<=Ix, o_valid<=1, counter increments.
  - Latency: the grant appears 1 cycle after the request; the first valid beat appears 1 cycle after the grant.
- Leaving Gx:
  - reqx=0: o_valid<=0, last_served<=x, counter<=0. Go to Gy if reqy=1, else IDLE.
  - Counter reaches MAX_HOLD with reqy=1: forced switch to Gy, last_served<=x, counter<=0. The beat on the switching edge is still from Ix.
  - Counter reaches MAX_HOLD with reqy=0: stay in Gx, counter wraps to 0. No gap in o_valid.
- Simultaneous events: reqx drop and reqy rise on the same edge -> direct Gx->Gy. There is no IDLE cycle and no overlap; gnt0 and gnt1 are never both high.
- Data is sampled only when granted; changes on the ungranted input never reach o.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - gcnt0/gcnt1 increment on every valid beat of their requester.
  - 16-bit wrap-around (0xFFFF -> 0x0000).
  - Both cleared by reset.
- Undefined: the counters are not built; gcnt0/gcnt1 are tied to 0.

Decomposition:
- Shared header arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2;
  - default MAX_HOLD;
  - the stats counter width.
- One sub-module, rr_pick: combinational next-owner logic. Inputs: req0, req1, last_served, current owner, hold-expired. Output: next state. It is reused by future 4-way arbiters.

Test Plan:
- Reset then req0=1, I0=8'hA5, req1=0 -> gnt0=1 one cycle later; o=8'hA5, o_valid=1 the cycle after; sel=0.
- req0 and req1 both rise on the same edge after reset -> G0 first; with MAX_HOLD=4, after 4 beats of I0, 4 beats of I1 follow with no idle gap; pattern repeats.
- req1 alone held for 10 cycles, I1 incrementing 8'h00..8'h09 -> continuous o_valid, o tracks I1 with 1-cycle lag, no dropout at the counter wrap.
- In G0, req0 falls on the same edge req1 rises -> next cycle gnt1=1, gnt0=0; gnt0&gnt1 is never 1 (assert every cycle).
- rst_n pulsed low mid-burst in G1 -> gnt1, o_valid and o go to 0 immediately without waiting for a clock; after release, with both requests pending, requester 0 is granted first.
- With ARB_STATS_EN defined: 3 beats from requester 0 and 5 from requester 1 -> gcnt0=3, gcnt1=5. Preload near 16'hFFFF -> wraps to 0.
